uart_bus_arbiter_n: RTL and testbench

- Parametrised successor to the two-UART bus arbiter: serves NUM_CH memory-mapped UART channels.
- Captures RX-ready and TX-done events as sticky per-channel pending bits.
- Writes each event into its channel's memory window through a registered round-robin grant FSM; CPU accesses always win the bus.
- Sits between the CPU data-memory port, the UART channels and the data-memory write mux.

---
 rtl/uart_bus_arbiter_n_pkg.sv | 29 ++
 rtl/uart_bus_arbiter_n_if.sv | 28 ++
 rtl/uart_bus_arbiter_n_rr_picker.sv | 31 +++
 rtl/uart_bus_arbiter_n.sv | 167 ++++++++++++++++
 tb/tb_uart_bus_arbiter_n.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bus_arbiter_n_pkg.sv
// Shared constants and encodings for the N-channel UART bus arbiter.
// Window offsets are byte offsets inside each channel's memory window.
package uart_bus_arbiter_n_pkg;

  localparam int unsigned UART_OFF_TXDATA = 0;
  localparam int unsigned UART_OFF_RXDATA = 4;
  localparam int unsigned UART_OFF_RXFLAG = 8;
  localparam int unsigned UART_OFF_TXDONE = 12;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    EV_RXDATA = 2'd0,
    EV_RXFLAG = 2'd1,
    EV_TXDONE = 2'd2
  } ev_type_e;

  function automatic logic [31:0] ev_offset(ev_type_e ev);
    case (ev)
      EV_TXDONE: return UART_OFF_TXDONE;
      EV_RXFLAG: return UART_OFF_RXFLAG;
      default:   return UART_OFF_RXDATA;
    endcase
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_n_if.sv
// Bus bundle between the CPU data port, the UART channels and the arbiter.
// The arbiter uses the slave modport; the CPU/UART side uses master.
interface uart_bus_arbiter_n_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              memReadCPU;
  logic              memWriteCPU;
  logic [NUM_CH-1:0] readyRx;
  logic [NUM_CH-1:0] busyTx;
  logic [NUM_CH-1:0] txEnable;
  logic              memWriteOut;
  logic [NUM_CH-1:0] uartToMem;
  logic [ADDR_W-1:0] uartAddress;
  logic              uartDataSel;
  logic [NUM_CH-1:0] rxOverrun;

  modport slave (
    input  address, memReadCPU, memWriteCPU, readyRx, busyTx,
    output txEnable, memWriteOut, uartToMem, uartAddress, uartDataSel, rxOverrun
  );

  modport master (
    output address, memReadCPU, memWriteCPU, readyRx, busyTx,
    input  txEnable, memWriteOut, uartToMem, uartAddress, uartDataSel, rxOverrun
  );
endinterface

// File: rtl/uart_bus_arbiter_n_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping from NUM_CH-1 back to 0.
module uart_bus_arbiter_n_rr_picker #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  always_comb begin : pick
    int unsigned c;
    c       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      c = 32'(ptr_i) + off;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!valid_o && req_i[IDX_W'(c)]) begin
        valid_o              = 1'b1;
        grant_o[IDX_W'(c)]   = 1'b1;
        idx_o                = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/uart_bus_arbiter_n.sv
// N-channel UART event arbiter: captures RX/TX events as sticky pending bits and
// writes them into each channel's memory window whenever the CPU leaves the bus free.
module uart_bus_arbiter_n
  import uart_bus_arbiter_n_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] UART_BASE = 32'h0000_0F00,
  parameter int unsigned       CH_STRIDE = 16
) (
  input logic                 clk,
  input logic                 reset,
  uart_bus_arbiter_n_if.slave bus_if
);

  // state     | meaning
  // ARB_IDLE  | no write owned; pick next pending event when the bus is free
  // ARB_WRITE | grant registered; write fires on the first bus-free cycle

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic              bus_free;
  logic [NUM_CH-1:0] ready_rx_dly_q, busy_tx_dly_q;
  logic [NUM_CH-1:0] rx_rise, tx_fall;
  logic [NUM_CH-1:0] rx_data_pend_q, rx_data_pend_d;
  logic [NUM_CH-1:0] rx_flag_pend_q, rx_flag_pend_d;
  logic [NUM_CH-1:0] tx_done_pend_q, tx_done_pend_d;
  logic [NUM_CH-1:0] clr_rx_data, clr_rx_flag, clr_tx_done, set_rx_flag;
  logic [NUM_CH-1:0] rx_overrun_q, tx_en;

  logic [NUM_CH-1:0] req, pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  ev_type_e          pick_ev;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [NUM_CH-1:0] gnt_onehot_q, gnt_onehot_d;
  ev_type_e          ev_q, ev_d;
  logic [ADDR_W-1:0] uart_addr_q, uart_addr_d;
  logic              data_sel_q, data_sel_d;

  assign bus_free = !(bus_if.memReadCPU || bus_if.memWriteCPU);
  assign rx_rise  = bus_if.readyRx & ~ready_rx_dly_q;
  assign tx_fall  = ~bus_if.busyTx & busy_tx_dly_q;
  assign req      = rx_data_pend_q | rx_flag_pend_q | tx_done_pend_q;

  uart_bus_arbiter_n_rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_picker (
    .req_i   (req),
    .ptr_i   (rr_q),
    .grant_o (pick_onehot),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_ev = EV_RXDATA;
    if (tx_done_pend_q[pick_idx])      pick_ev = EV_TXDONE;
    else if (rx_flag_pend_q[pick_idx]) pick_ev = EV_RXFLAG;
  end

  // Set terms are ORed in last so a new edge re-queues an event being cleared.
  always_comb begin
    clr_rx_data = '0;
    clr_rx_flag = '0;
    clr_tx_done = '0;
    set_rx_flag = '0;
    if (state_q == ARB_WRITE && bus_free) begin
      case (ev_q)
        EV_TXDONE: clr_tx_done = gnt_onehot_q;
        EV_RXFLAG: clr_rx_flag = gnt_onehot_q;
        default: begin
          clr_rx_data = gnt_onehot_q;
          set_rx_flag = gnt_onehot_q;
        end
      endcase
    end
  end

  assign rx_data_pend_d = (rx_data_pend_q & ~clr_rx_data) | rx_rise;
  assign rx_flag_pend_d = (rx_flag_pend_q & ~clr_rx_flag) | set_rx_flag;
  assign tx_done_pend_d = (tx_done_pend_q & ~clr_tx_done) | tx_fall;

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    ev_d         = ev_q;
    uart_addr_d  = uart_addr_q;
    data_sel_d   = data_sel_q;
    rr_d         = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus_free && pick_valid) begin
          gnt_idx_d    = pick_idx;
          gnt_onehot_d = pick_onehot;
          ev_d         = pick_ev;
          uart_addr_d  = UART_BASE + ADDR_W'(pick_idx) * ADDR_W'(CH_STRIDE)
                         + ADDR_W'(ev_offset(pick_ev));
          data_sel_d   = (pick_ev != EV_RXDATA);
          state_d      = ARB_WRITE;
        end
      end
      ARB_WRITE: begin
        if (bus_free) begin
          gnt_onehot_d = '0;
          rr_d         = (gnt_idx_q == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx_q + 1'b1;
          state_d      = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      gnt_idx_q      <= '0;
      gnt_onehot_q   <= '0;
      ev_q           <= EV_RXDATA;
      uart_addr_q    <= '0;
      data_sel_q     <= 1'b0;
      rr_q           <= '0;
      ready_rx_dly_q <= '0;
      busy_tx_dly_q  <= '0;
      rx_data_pend_q <= '0;
      rx_flag_pend_q <= '0;
      tx_done_pend_q <= '0;
      rx_overrun_q   <= '0;
    end else begin
      state_q        <= state_d;
      gnt_idx_q      <= gnt_idx_d;
      gnt_onehot_q   <= gnt_onehot_d;
      ev_q           <= ev_d;
      uart_addr_q    <= uart_addr_d;
      data_sel_q     <= data_sel_d;
      rr_q           <= rr_d;
      ready_rx_dly_q <= bus_if.readyRx;
      busy_tx_dly_q  <= bus_if.busyTx;
      rx_data_pend_q <= rx_data_pend_d;
      rx_flag_pend_q <= rx_flag_pend_d;
      tx_done_pend_q <= tx_done_pend_d;
      rx_overrun_q   <= rx_rise & rx_data_pend_q;
    end
  end

  // A TX start is only allowed once the previous completion has been fully reported.
  always_comb begin
    tx_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tx_en[i] = !reset && bus_if.memWriteCPU
                 && (bus_if.address == UART_BASE + ADDR_W'(i * CH_STRIDE + UART_OFF_TXDATA))
                 && !bus_if.busyTx[i] && !busy_tx_dly_q[i] && !tx_done_pend_q[i];
    end
  end

  assign bus_if.txEnable    = tx_en;
  assign bus_if.memWriteOut = (state_q == ARB_WRITE) && bus_free;
  assign bus_if.uartToMem   = gnt_onehot_q;
  assign bus_if.uartAddress = uart_addr_q;
  assign bus_if.uartDataSel = data_sel_q;
  assign bus_if.rxOverrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_bus_arbiter_n.sv
// Directed bench for uart_bus_arbiter_n: a queue/array event model checked every
// cycle, plus literal expectations for the scenario write sequences.
module tb_uart_bus_arbiter_n;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_0F00;
  localparam int          E_RXD = 0, E_RXF = 1, E_TXD = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  uart_bus_arbiter_n_if #(.NUM_CH(N), .ADDR_W(32)) bus_if ();

  uart_bus_arbiter_n #(
    .NUM_CH(N), .ADDR_W(32), .UART_BASE(BASE), .CH_STRIDE(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Event model: sticky pending sets per channel, one outstanding grant record.
  bit [N-1:0] m_rxd, m_rxf, m_txd, m_prev_rx, m_prev_tx, m_ovr;
  bit         m_gv;
  int         m_gch, m_gev, m_rr;

  always @(posedge clk or posedge reset) begin
    bit free;
    bit [N-1:0] rx, tx, orxd, orxf, otxd;
    int c;
    if (reset) begin
      m_rxd = '0; m_rxf = '0; m_txd = '0; m_prev_rx = '0; m_prev_tx = '0; m_ovr = '0;
      m_gv = 0; m_gch = 0; m_gev = E_RXD; m_rr = 0;
    end else begin
      free = !(bus_if.memReadCPU || bus_if.memWriteCPU);
      rx = bus_if.readyRx; tx = bus_if.busyTx;
      orxd = m_rxd; orxf = m_rxf; otxd = m_txd;
      for (int i = 0; i < N; i++) m_ovr[i] = rx[i] && !m_prev_rx[i] && orxd[i];
      if (m_gv) begin
        if (free) begin
          if (m_gev == E_TXD) m_txd[m_gch] = 0;
          else if (m_gev == E_RXF) m_rxf[m_gch] = 0;
          else begin m_rxd[m_gch] = 0; m_rxf[m_gch] = 1; end
          m_rr = (m_gch + 1) % N;
          m_gv = 0;
        end
      end else if (free) begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!m_gv && (orxd[c] || orxf[c] || otxd[c])) begin
            m_gv = 1; m_gch = c;
            m_gev = otxd[c] ? E_TXD : (orxf[c] ? E_RXF : E_RXD);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rx[i] && !m_prev_rx[i]) m_rxd[i] = 1;
        if (!tx[i] && m_prev_tx[i]) m_txd[i] = 1;
      end
      m_prev_rx = rx; m_prev_tx = tx;
    end
  end

  logic [31:0] log_addr[$];
  bit          log_sel[$];
  int          log_cyc[$];
  int          ovr_cnt = 0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    bit free;
    bit [N-1:0] etx, eg;
    int off;
    free = !(bus_if.memReadCPU || bus_if.memWriteCPU);
    eg = m_gv ? (N'(1) << m_gch) : '0;
    for (int i = 0; i < N; i++)
      etx[i] = !reset && bus_if.memWriteCPU && (bus_if.address == BASE + 32'(16 * i))
               && !bus_if.busyTx[i] && !m_prev_tx[i] && !m_txd[i];
    chk("txEnable", 32'(bus_if.txEnable), 32'(etx));
    chk("uartToMem", 32'(bus_if.uartToMem), 32'(eg));
    chk("memWriteOut", 32'(bus_if.memWriteOut), 32'(m_gv && free));
    chk("rxOverrun", 32'(bus_if.rxOverrun), 32'(m_ovr));
    if (m_gv) begin
      off = (m_gev == E_TXD) ? 12 : ((m_gev == E_RXF) ? 8 : 4);
      chk("uartAddress", bus_if.uartAddress, BASE + 32'(m_gch * 16 + off));
      chk("uartDataSel", 32'(bus_if.uartDataSel), 32'(m_gev != E_RXD));
    end
    if (bus_if.memWriteOut === 1'b1) begin
      log_addr.push_back(bus_if.uartAddress);
      log_sel.push_back(bus_if.uartDataSel);
      log_cyc.push_back(cyc);
    end
    if (bus_if.rxOverrun[0] === 1'b1) ovr_cnt++;
    if (bus_if.uartToMem === 4'b0010 && bus_if.memWriteOut === 1'b0) stall_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic log_clear();
    log_addr.delete(); log_sel.delete(); log_cyc.delete();
  endtask

  function automatic logic [31:0] log_a(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_s(input int i);
    return (i < log_sel.size()) ? 32'(log_sel[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_memWriteOut"}, 32'(bus_if.memWriteOut), 0);
    chk({tag, "_uartToMem"},   32'(bus_if.uartToMem), 0);
    chk({tag, "_uartAddress"}, bus_if.uartAddress, 0);
    chk({tag, "_uartDataSel"}, 32'(bus_if.uartDataSel), 0);
    chk({tag, "_rxOverrun"},   32'(bus_if.rxOverrun), 0);
    chk({tag, "_txEnable"},    32'(bus_if.txEnable), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp3_addr[6] = '{32'hF14, 32'hF34, 32'hF04, 32'hF18, 32'hF38, 32'hF08};
  bit          exp3_sel[6]  = '{0, 0, 0, 1, 1, 1};

  initial begin
    bit seen;
    int c0;
    bus_if.address = '0; bus_if.memReadCPU = 0; bus_if.memWriteCPU = 0;
    bus_if.readyRx = '0; bus_if.busyTx = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #2 reset = 1'b0;
    tick(2);

    // Reset mid-write drops the event.
    bus_if.readyRx[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      if (bus_if.memWriteOut === 1'b1) seen = 1;
    end
    chk("t1_write_seen", 32'(seen), 1);
    #1 reset = 1'b1;
    #1 check_outputs_zero("t1_midwrite");
    bus_if.readyRx = '0;
    @(posedge clk); #2 reset = 1'b0;
    log_clear();
    tick(10);
    chk("t1_no_write_after", log_addr.size(), 0);

    // Single RX on channel 2.
    log_clear();
    bus_if.readyRx[2] = 1'b1;
    c0 = cyc;
    tick(8);
    bus_if.readyRx = '0;
    tick(2);
    chk("t2_count", log_addr.size(), 2);
    chk("t2_addr0", log_a(0), 32'hF24);
    chk("t2_sel0", log_s(0), 0);
    chk("t2_addr1", log_a(1), 32'hF28);
    chk("t2_sel1", log_s(1), 1);
    if (log_cyc.size() == 2) begin
      chk("t2_latency", 32'(log_cyc[0] - c0), 2);
      chk("t2_spacing", 32'(log_cyc[1] - log_cyc[0]), 2);
    end else begin
      chk("t2_timing_entries", log_cyc.size(), 2);
    end

    // Channel 0 event moves the pointer to 1, then three simultaneous RX edges.
    bus_if.readyRx[0] = 1'b1;
    tick(8);
    bus_if.readyRx = '0;
    tick(2);
    log_clear();
    bus_if.readyRx = 4'b1011;
    tick(16);
    bus_if.readyRx = '0;
    tick(2);
    chk("t3_count", log_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_addr%0d", i), log_a(i), exp3_addr[i]);
      chk($sformatf("t3_sel%0d", i), log_s(i), 32'(exp3_sel[i]));
    end

    // CPU holds the bus while a TX-done write is granted on channel 1.
    bus_if.busyTx[1] = 1'b1;
    tick(3);
    log_clear();
    stall_cnt = 0;
    bus_if.busyTx[1] = 1'b0;
    tick(2);
    bus_if.address = 32'h100;
    bus_if.memWriteCPU = 1'b1;
    tick(5);
    bus_if.memWriteCPU = 1'b0;
    c0 = cyc;
    tick(4);
    chk("t4_stall_cycles", stall_cnt, 5);
    chk("t4_count", log_addr.size(), 1);
    chk("t4_addr", log_a(0), 32'hF1C);
    chk("t4_sel", log_s(0), 1);
    if (log_cyc.size() > 0) chk("t4_first_free", 32'(log_cyc[0]), 32'(c0));

    // TX start gating.
    bus_if.busyTx[1] = 1'b1;
    tick(3);
    bus_if.address = BASE + 32'h10;
    bus_if.memWriteCPU = 1'b1;
    @(negedge clk);
    chk("t5_busy_blocks", 32'(bus_if.txEnable), 0);
    @(posedge clk); #2;
    bus_if.memWriteCPU = 1'b0;
    bus_if.busyTx[1] = 1'b0;
    tick(8);
    bus_if.memWriteCPU = 1'b1;
    @(negedge clk);
    chk("t5_enable", 32'(bus_if.txEnable), 32'h2);
    @(posedge clk); #2;
    bus_if.memWriteCPU = 1'b0;
    @(negedge clk);
    chk("t5_enable_one_cycle", 32'(bus_if.txEnable), 0);
    tick(2);

    // Two RX edges on channel 0 while the CPU owns the bus.
    log_clear();
    ovr_cnt = 0;
    bus_if.address = 32'h100;
    bus_if.memWriteCPU = 1'b1;
    tick(1);
    bus_if.readyRx[0] = 1'b1; tick(1);
    bus_if.readyRx[0] = 1'b0; tick(1);
    bus_if.readyRx[0] = 1'b1; tick(1);
    bus_if.readyRx[0] = 1'b0; tick(3);
    chk("t6_no_write_while_busy", log_addr.size(), 0);
    bus_if.memWriteCPU = 1'b0;
    tick(8);
    chk("t6_overrun_pulses", ovr_cnt, 1);
    chk("t6_count", log_addr.size(), 2);
    chk("t6_addr0", log_a(0), 32'hF04);
    chk("t6_sel0", log_s(0), 0);
    chk("t6_addr1", log_a(1), 32'hF08);
    chk("t6_sel1", log_s(1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
